// File: rtl/vec_capture_pkg.sv
// Shared types and default sizing for the vector capture recorder.
// The state encoding is fixed so the state can be probed in emulation.
// Widths here are defaults only; instances may override them.
package vec_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int VEC_WIDTH_DEF  = 15;
  localparam int DEPTH_DEF      = 10;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int SKIP_WIDTH_DEF = 8;

endpackage

// File: rtl/vec_capture_mem.sv
// Simple dual-port vector RAM: one write port, one registered read port.
// Read latency one cycle; a read of the slot written on the same edge
// returns the old contents. No backpressure; one access per port per cycle.
module vec_capture_mem
  import vec_capture_pkg::*;
#(
  parameter int VEC_WIDTH  = VEC_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [VEC_WIDTH-1:0]  wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [VEC_WIDTH-1:0]  rd_data
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_C = ADDR_WIDTH'(DEPTH);

  logic [VEC_WIDTH-1:0] mem [DEPTH];
  logic [VEC_WIDTH-1:0] rd_data_d, rd_data_q;

  // Storage array: written on the edge, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read mux sees the pre-edge array, which gives read-old-data on collision.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_addr < DEPTH_C) begin
        rd_data_d = mem[rd_addr];
      end else begin
        rd_data_d = '0;
      end
    end
  end

  // Read output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vec_capture.sv
// Capture recorder: stores qualified sample vectors after an optional skip.
// Samples land in memory on their own edge; reads return one cycle later.
// No backpressure: one sample and one read accepted every cycle.
module vec_capture
  import vec_capture_pkg::*;
#(
  parameter int VEC_WIDTH  = VEC_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SKIP_WIDTH = SKIP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [SKIP_WIDTH-1:0] skip_cycles,
  input  logic                  sample_en,
  input  logic [VEC_WIDTH-1:0]  sample_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [VEC_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_C   = ADDR_WIDTH'(DEPTH);
  localparam logic [SKIP_WIDTH-1:0] SKIP_ONE  = SKIP_WIDTH'(1);

  state_e                state_d, state_q;
  logic [SKIP_WIDTH-1:0] skip_cnt_d, skip_cnt_q;
  logic [ADDR_WIDTH-1:0] count_d, count_q;
  logic                  overflow_d, overflow_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic                  full_d, full_q;
  logic                  rd_valid_d, rd_valid_q;
  logic                  in_range_d, in_range_q;
  logic                  wr_en;
  logic [VEC_WIDTH-1:0]  mem_rd_data;

  // Next-state, counters and sticky overflow; stop outranks start while armed.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          count_d    = '0;
          overflow_d = 1'b0;
          skip_cnt_d = skip_cycles;
          state_d    = (skip_cycles == '0) ? ST_CAPTURE : ST_SKIP;
        end else if (state_q == ST_DONE && sample_en) begin
          overflow_d = 1'b1;
        end
      end
      ST_SKIP: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (sample_en) begin
          skip_cnt_d = skip_cnt_q - 1'b1;
          if (skip_cnt_q == SKIP_ONE) begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        // CAPTURE always has a free slot: the filling write leaves the state.
        if (sample_en) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST_SLOT) begin
            state_d = ST_DONE;
          end
        end
        if (stop) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from next-state so they move with the write.
  always_comb begin
    busy_d     = (state_d == ST_SKIP) || (state_d == ST_CAPTURE);
    done_d     = (state_d == ST_DONE);
    full_d     = (count_d == DEPTH_C);
    rd_valid_d = rd_en;
    in_range_d = in_range_q;
    if (rd_en) begin
      in_range_d = (rd_addr < count_q);
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      skip_cnt_q <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      in_range_q <= in_range_d;
    end
  end

  vec_capture_mem #(
    .VEC_WIDTH  (VEC_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (count_q),
    .wr_data (sample_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (mem_rd_data)
  );

  // Slots at or beyond the captured count read back as zero.
  assign rd_data  = in_range_q ? mem_rd_data : '0;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign full     = full_q;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule
